// File: rtl/gray_track_decoder.sv
// gray_track_decoder
// Tracks a Gray-coded step counter: converts each sample to binary, extends
// it with a revolution (wrap) counter and checks that every observed change
// is a legal single forward step. The first illegal transition latches a
// fault and its cause until Clear or Reset.
// Optional build macro GRAY_TRACK_SYNC2_EN: when defined, GrayIn and OvfIn
// pass through a 2-flop synchroniser, adding two cycles of latency.
module gray_track_decoder #(
   parameter int GW    = 3,
   parameter int WRAPW = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Clear,
   input  logic [GW-1:0]         GrayIn,
   input  logic                  OvfIn,
   output logic [GW-1:0]         BinOut,
   output logic [WRAPW+GW-1:0]   Count,
   output logic                  Step,
   output logic                  Wrap,
   output logic                  Sat,
   output logic                  Err,
   output logic [1:0]            ErrCode
);

   typedef enum logic [0:0] {
      ST_TRACK = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   localparam logic [GW-1:0]    LP_BIN_ONE  = {{(GW-1){1'b0}}, 1'b1};
   localparam logic [GW-1:0]    LP_BIN_MAX  = {GW{1'b1}};
   localparam logic [WRAPW-1:0] LP_WRAP_ONE = {{(WRAPW-1){1'b0}}, 1'b1};
   localparam logic [WRAPW-1:0] LP_WRAP_MAX = {WRAPW{1'b1}};

   localparam logic [1:0] LP_CODE_NONE = 2'b00;
   localparam logic [1:0] LP_CODE_JUMP = 2'b01;
   localparam logic [1:0] LP_CODE_BACK = 2'b10;
   localparam logic [1:0] LP_CODE_OVF  = 2'b11;

   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int popcount(input logic [GW-1:0] v);
      int cnt;
      cnt = 32'sd0;
      for (int i = 0; i < GW; i++) begin
         if (v[i]) begin
            cnt = cnt + 32'sd1;
         end
      end
      return cnt;
   endfunction

   logic [GW-1:0]    w_g_in;
   logic             w_ovf_in;

`ifdef GRAY_TRACK_SYNC2_EN
   logic [GW-1:0]    r_sync1_g;
   logic [GW-1:0]    r_sync2_g;
   logic             r_sync1_ovf;
   logic             r_sync2_ovf;

   // Two-flop synchroniser for inputs arriving from another clock domain.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_sync1_g   <= {GW{1'b0}};
         r_sync2_g   <= {GW{1'b0}};
         r_sync1_ovf <= 1'b0;
         r_sync2_ovf <= 1'b0;
      end else begin
         r_sync1_g   <= GrayIn;
         r_sync2_g   <= r_sync1_g;
         r_sync1_ovf <= OvfIn;
         r_sync2_ovf <= r_sync1_ovf;
      end
   end

   assign w_g_in   = r_sync2_g;
   assign w_ovf_in = r_sync2_ovf;
`else
   assign w_g_in   = GrayIn;
   assign w_ovf_in = OvfIn;
`endif

   state_t           r_state;
   logic [GW-1:0]    r_g_q;
   logic             r_ovf_q;
   logic             r_ovf_prev;
   logic [GW-1:0]    r_g_last;
   logic             r_wrap_seen;
   logic [WRAPW-1:0] r_wraps;
   logic [GW-1:0]    r_bin;
   logic             r_step;
   logic             r_wrap;
   logic             r_sat;
   logic             r_err;
   logic [1:0]       r_err_code;

   logic [GW-1:0]    w_b_new;
   logic [GW-1:0]    w_b_last;
   int               w_pc;
   logic             w_fwd;
   logic             w_bwd;
   logic             w_jump;
   logic             w_wrap_acc;
   logic             w_ovf_bad;
   logic [WRAPW-1:0] w_wraps_nxt;

   // Classify the transition from the last accepted sample to the current one.
   // A single-bit change that is neither +1 nor -1 in binary is treated as a
   // jump, since it cannot come from one legal counter step.
   always_comb begin
      w_b_new     = gray2bin(r_g_q);
      w_b_last    = gray2bin(r_g_last);
      w_pc        = popcount(r_g_q ^ r_g_last);
      w_fwd       = (w_pc == 32'sd1) && (w_b_new == (w_b_last + LP_BIN_ONE));
      w_bwd       = (w_pc == 32'sd1) && (w_b_new == (w_b_last - LP_BIN_ONE));
      w_jump      = (w_pc != 32'sd0) && !w_fwd && !w_bwd;
      w_wrap_acc  = w_fwd && (w_b_last == LP_BIN_MAX);
      w_ovf_bad   = (r_ovf_q && !r_ovf_prev && !w_wrap_acc) ||
                    (w_wrap_acc && !r_wrap_seen && !r_ovf_q);
      if (r_wraps == LP_WRAP_MAX) begin
         w_wraps_nxt = r_wraps;
      end else begin
         w_wraps_nxt = r_wraps + LP_WRAP_ONE;
      end
   end

   // Sample stage plus tracking FSM; all outputs are registered here.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_TRACK;
         r_g_q       <= {GW{1'b0}};
         r_ovf_q     <= 1'b0;
         r_ovf_prev  <= 1'b0;
         r_g_last    <= {GW{1'b0}};
         r_wrap_seen <= 1'b0;
         r_wraps     <= {WRAPW{1'b0}};
         r_bin       <= {GW{1'b0}};
         r_step      <= 1'b0;
         r_wrap      <= 1'b0;
         r_sat       <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= LP_CODE_NONE;
      end else begin
         r_g_q      <= w_g_in;
         r_ovf_q    <= w_ovf_in;
         r_ovf_prev <= r_ovf_q;
         r_step     <= 1'b0;
         r_wrap     <= 1'b0;
         case (r_state)
            ST_TRACK: begin
               if (Clear) begin
                  r_g_last <= r_g_q;
               end else if (w_jump) begin
                  r_state    <= ST_FAULT;
                  r_err      <= 1'b1;
                  r_err_code <= LP_CODE_JUMP;
               end else if (w_bwd) begin
                  r_state    <= ST_FAULT;
                  r_err      <= 1'b1;
                  r_err_code <= LP_CODE_BACK;
               end else if (w_ovf_bad) begin
                  r_state    <= ST_FAULT;
                  r_err      <= 1'b1;
                  r_err_code <= LP_CODE_OVF;
               end else if (w_fwd) begin
                  r_g_last <= r_g_q;
                  r_bin    <= w_b_new;
                  r_step   <= 1'b1;
                  if (w_wrap_acc) begin
                     r_wrap      <= 1'b1;
                     r_wrap_seen <= 1'b1;
                     r_wraps     <= w_wraps_nxt;
                     r_sat       <= r_sat | (w_wraps_nxt == LP_WRAP_MAX);
                  end else begin
                     r_wrap <= 1'b0;
                  end
               end else begin
                  r_g_last <= r_g_last;
               end
            end
            ST_FAULT: begin
               if (Clear) begin
                  r_state     <= ST_TRACK;
                  r_g_last    <= r_g_q;
                  r_bin       <= w_b_new;
                  r_err       <= 1'b0;
                  r_err_code  <= LP_CODE_NONE;
                  r_wrap_seen <= 1'b0;
               end else begin
                  r_state <= ST_FAULT;
               end
            end
            default: begin
               r_state    <= ST_FAULT;
               r_err      <= 1'b1;
               r_err_code <= LP_CODE_JUMP;
            end
         endcase
      end
   end

   assign BinOut  = r_bin;
   assign Count   = {r_wraps, r_bin};
   assign Step    = r_step;
   assign Wrap    = r_wrap;
   assign Sat     = r_sat;
   assign Err     = r_err;
   assign ErrCode = r_err_code;

endmodule

// File: tb/tb_gray_track_decoder.sv
// Scoreboard bench for gray_track_decoder: the stimulus process pushes the
// hand-computed response expected at a given cycle; a monitor process pops
// and compares on the falling edge of that cycle.
module tb_gray_track_decoder;

   localparam int GW    = 3;
   localparam int WRAPW = 8;
`ifdef GRAY_TRACK_SYNC2_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Clear;
   logic [GW-1:0]     GrayIn;
   logic              OvfIn;
   logic [GW-1:0]     BinOut;
   logic [WRAPW+GW-1:0] Count;
   logic              Step;
   logic              Wrap;
   logic              Sat;
   logic              Err;
   logic [1:0]        ErrCode;

   gray_track_decoder #(.GW(GW), .WRAPW(WRAPW)) dut (
      .Clk(Clk), .Reset(Reset), .Clear(Clear), .GrayIn(GrayIn), .OvfIn(OvfIn),
      .BinOut(BinOut), .Count(Count), .Step(Step), .Wrap(Wrap), .Sat(Sat),
      .Err(Err), .ErrCode(ErrCode)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [2:0]  bin;
      logic [10:0] cnt;
      logic        step;
      logic        wrap;
      logic        sat;
      logic        err;
      logic [1:0]  code;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int due, input logic [2:0] bin, input logic [7:0] wraps,
                       input logic step, input logic wrap, input logic sat,
                       input logic err, input logic [1:0] code);
      exp_t e;
      e.due = due; e.bin = bin; e.cnt = {wraps, bin};
      e.step = step; e.wrap = wrap; e.sat = sat; e.err = err; e.code = code;
      q.push_back(e);
   endtask

   // One cycle of stimulus; the response shows up LAT cycles later.
   task automatic step_v(input logic [2:0] g, input logic o,
                         input logic [2:0] bin, input logic [7:0] wraps,
                         input logic step, input logic wrap, input logic sat,
                         input logic err, input logic [1:0] code);
      @(posedge Clk); #1;
      GrayIn = g; OvfIn = o;
      push(cyc + LAT, bin, wraps, step, wrap, sat, err, code);
   endtask

   // Hold current inputs, unchecked, long enough to drain the pipeline.
   task automatic settle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic clear_pulse(input logic [2:0] bin, input logic [7:0] wraps, input logic sat);
      settle(LAT);
      @(posedge Clk); #1;
      Clear = 1'b1;
      push(cyc + 1, bin, wraps, 1'b0, 1'b0, sat, 1'b0, 2'b00);
      @(posedge Clk); #1;
      Clear = 1'b0;
   endtask

   task automatic reset_pulse(input logic clr);
      settle(LAT);
      @(posedge Clk); #1;
      Reset = 1'b1; Clear = clr; GrayIn = 3'b000; OvfIn = 1'b0;
      push(cyc + 1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      @(posedge Clk); #1;
      Reset = 1'b0; Clear = 1'b0;
      settle(LAT);
   endtask

   // Monitor: compare the scheduled expectation on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missed_check: due cycle %0d, now %0d", e.due, cyc);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("BinOut",  {8'd0, BinOut},   {8'd0, e.bin});
            chk("Count",   Count,            e.cnt);
            chk("Step",    {10'd0, Step},    {10'd0, e.step});
            chk("Wrap",    {10'd0, Wrap},    {10'd0, e.wrap});
            chk("Sat",     {10'd0, Sat},     {10'd0, e.sat});
            chk("Err",     {10'd0, Err},     {10'd0, e.err});
            chk("ErrCode", {9'd0, ErrCode},  {9'd0, e.code});
         end
      end
   end

   initial begin
      int wr;
      Reset = 1'b1; Clear = 1'b0; GrayIn = 3'b000; OvfIn = 1'b0;
      @(posedge Clk); #1;
      push(cyc + 1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      @(posedge Clk); #1;
      Reset = 1'b0;
      settle(LAT);

      // One full revolution; overflow rises together with the wrap.
      step_v(3'b001, 1'b0, 3'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b011, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b010, 1'b0, 3'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b110, 1'b0, 3'd4, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b111, 1'b0, 3'd5, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b101, 1'b0, 3'd6, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b100, 1'b0, 3'd7, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b000, 1'b1, 3'd0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
      step_v(3'b000, 1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

      // Multi-bit jump from bin 3 (010) to 101, then Clear adopts bin 6.
      step_v(3'b001, 1'b1, 3'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b011, 1'b1, 3'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b010, 1'b1, 3'd3, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b101, 1'b1, 3'd3, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
      step_v(3'b101, 1'b1, 3'd3, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
      clear_pulse(3'd6, 8'd1, 1'b0);
      step_v(3'b101, 1'b1, 3'd6, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

      // Backward step 011 -> 001; a later forward 010 is ignored until Clear.
      step_v(3'b100, 1'b1, 3'd7, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b000, 1'b1, 3'd0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
      step_v(3'b001, 1'b1, 3'd1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b011, 1'b1, 3'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b001, 1'b1, 3'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
      step_v(3'b010, 1'b1, 3'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
      clear_pulse(3'd3, 8'd2, 1'b0);
      step_v(3'b010, 1'b1, 3'd3, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

      // Overflow rises while the code holds at 011.
      reset_pulse(1'b0);
      step_v(3'b001, 1'b0, 3'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b011, 1'b0, 3'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      step_v(3'b011, 1'b1, 3'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

      // First wrap with overflow still low.
      reset_pulse(1'b0);
      for (int i = 1; i < 8; i++) begin
         step_v(gtab[i], 1'b0, 3'(i), 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      end
      step_v(3'b000, 1'b0, 3'd7, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

      // Jump together with an overflow rise: jump wins.
      reset_pulse(1'b0);
      step_v(3'b011, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);

      // Reset while in FAULT with Clear also high.
      reset_pulse(1'b1);

      // 256 revolutions: wrap counter saturates at 0xFF, binary keeps going.
      for (int r = 0; r < 256; r++) begin
         for (int i = 1; i <= 8; i++) begin
            wr = r + ((i == 8) ? 1 : 0);
            if (wr > 255) wr = 255;
            step_v(gtab[i % 8], (r > 0) || (i == 8), 3'(i % 8), 8'(wr),
                   1'b1, (i == 8), (wr == 255), 1'b0, 2'b00);
         end
      end

      settle(LAT + 2);
      if (q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL leftover_checks: %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_track_decoder.md
Name: gray_track_decoder

Overview:
- Downstream consumer of the 3-bit Gray step counter; samples its Gray code and Overflow outputs every cycle.
- Converts Gray to binary and extends the count with a wrap counter.
- Checks every observed transition for legal single-step forward motion and flags faults to the controller.
- Needs a Clear input to resynchronise after a fault without a full Reset.

Parameters:
- GW, 3, Gray code width (must match upstream counter).
- WRAPW, 8, width of the wrap (revolution) counter.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Clear  input  1  sync resync request: leave FAULT, adopt current sample as baseline.
- GrayIn  input  GW  Gray code from upstream counter.
- OvfIn  input  1  sticky overflow flag from upstream counter.
- BinOut  output  GW  registered binary equivalent of last accepted sample.
- Count  output  WRAPW+GW  registered extended count {wraps, BinOut}.
- Step  output  1  one-cycle pulse per accepted forward step.
- Wrap  output  1  one-cycle pulse when an accepted step goes from binary max to 0.
- Sat  output  1  sticky; wrap counter reached all-ones.
- Err  output  1  sticky fault flag (high exactly while in FAULT).
- ErrCode  output  2  cause of first fault: 00 none, 01 multi-bit jump, 10 backward step, 11 overflow mismatch.

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clk): all outputs 0; g_q, ovf_q, g_last = 0; wraps = 0; state TRACK.
- Stage 1: every edge g_q <= GrayIn, ovf_q <= OvfIn.
- Stage 2: compare g_q against g_last; outputs registered. Input-to-output latency 2 cycles.
- Conversion: b[GW-1] = g[GW-1]; b[i] = b[i+1] ^ g[i].
- States: TRACK, FAULT.
- TRACK, g_q == g_last: hold; Step=Wrap=0.
- TRACK, popcount(g_q ^ g_last) == 1 and bin(g_q) == bin(g_last)+1 mod 2^GW: accept; g_last <= g_q; BinOut updates; Step=1.
- Accepted step from 2^GW-1 to 0: Wrap=1; wraps += 1. At all-ones wraps holds and Sat=1; Count then saturates its wrap field and the binary field continues.
- TRACK, popcount > 1: FAULT, ErrCode 01.
- TRACK, single-bit change equal to bin(g_last)-1: FAULT, ErrCode 10.
- Overflow mismatch: ovf_q rising (0->1) in a cycle with no Wrap, or the first Wrap since reset/Clear with ovf_q == 0 -> FAULT, ErrCode 11.
- Simultaneous causes: priority 01 > 10 > 11.
- FAULT: BinOut, Count, g_last frozen; Step=Wrap=0; Err=1; ErrCode held.
- Clear in FAULT: next edge -> TRACK; g_last <= g_q; BinOut <= bin(g_q); wraps kept; Err=0; ErrCode=00; first-wrap/ovf-edge tracking re-armed from current ovf_q.
- Clear in TRACK: only re-baselines g_last.
- Reset dominates Clear.
- Reset mid-operation clears everything next edge regardless of state.

Optional Feature:
- Macro: GRAY_TRACK_SYNC2_EN.
- Defined: GrayIn and OvfIn pass through a 2-flop synchroniser before stage 1; latency 4 cycles; synchroniser flops reset to 0.
- Undefined: no synchroniser; latency 2 cycles. Inputs must be same-clock-domain.

Test Plan:
- Reset, then GrayIn steps 000,001,011,010,110,111,101,100,000 one per cycle, OvfIn rises with the final 000 -> Step pulses 8 times; BinOut 1..7 then 0; Wrap once; Count = 0x008 (GW=3, WRAPW=8); Err=0.
- From BinOut=3 (010), drive GrayIn=101 -> Err=1, ErrCode=01 two cycles later; Count frozen. Assert Clear -> Err=0, BinOut=6.
- From 011 (bin 2), drive 001 -> ErrCode=10. A later 010 gives no Step until Clear.
- OvfIn rises while GrayIn holds 011 -> ErrCode=11.
- 255 full revolutions -> Sat=1, wraps stays 0xFF, BinOut still cycles.
- Reset asserted in FAULT with Clear also high -> all outputs 0 next edge.
- With GRAY_TRACK_SYNC2_EN defined, repeat the first scenario: each response 2 cycles later.
